vga_sync_receiver: RTL and testbench

Receive-side counterpart of the VGA timing generator: samples an incoming hsync/vsync/RGB stream at pixel-enable rate and recovers the pixel coordinates from the sync edges. It validates line and frame lengths against the 640x480 timing and flags any deviation. Once locked, it emits coordinate-tagged active pixels. It sits beside the display path as a loop-back checker and capture front end, fed from the same 50 MHz clock and pixel tick.

---
 rtl/vga_rx_pkg.sv | 39 +++
 rtl/vga_rx_crc16.sv | 45 ++++
 rtl/vga_sync_receiver.sv | 175 +++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// Shared definitions for the VGA sync receiver: 640x480 timing constants,
// receiver state encoding and the CRC-16-CCITT parameters that the optional
// frame checksum (VGA_RX_CRC_EN) uses.
package vga_rx_pkg;

   // Horizontal timing in pixel ticks
   localparam int H_DISPLAY    = 640;
   localparam int H_FRONT      = 16;
   localparam int H_SYNC       = 96;
   localparam int H_BACK       = 48;
   localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int H_SYNC_START = H_DISPLAY + H_FRONT;

   // Vertical timing in lines
   localparam int V_DISPLAY    = 480;
   localparam int V_FRONT      = 10;
   localparam int V_SYNC       = 2;
   localparam int V_BACK       = 33;
   localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int V_SYNC_START = V_DISPLAY + V_FRONT;

   // Asserted level of the incoming hsync/vsync
   localparam logic SYNC_POL = 1'b1;

   localparam int COORD_W = 10;
   localparam int RGB_W   = 30;

   // HUNT: waiting for a frame reference; CHECK: one frame under test; LOCKED: verified
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } rx_state_e;

   // CRC-16-CCITT over 30-bit pixel words, MSB first
   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/vga_rx_crc16.sv
// 30-bit-parallel CRC-16-CCITT accumulator. clear_i restarts from the init
// value; if enable_i is high in the same cycle the word is folded into the
// fresh seed, so the first pixel of a frame is never lost. Only used when
// the top is built with VGA_RX_CRC_EN.
module vga_rx_crc16
   import vga_rx_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [RGB_W-1:0] data_i,
   output logic [15:0]      crc_o
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;
   logic [15:0] seed;

   // Serial CRC definition unrolled over all data bits, MSB first
   function automatic logic [15:0] crcStep(input logic [15:0] crcIn, input logic [RGB_W-1:0] data);
      logic [15:0] c;
      c = crcIn;
      for (int i = RGB_W - 1; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // Pick the seed (fresh or running) and fold in the word when enabled
   always_comb begin
      seed  = clear_i ? CRC_INIT : crc_q;
      crc_d = enable_i ? crcStep(seed, data_i) : seed;
   end

   // Accumulator register, updated only when something happens
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                 crc_q <= CRC_INIT;
      else if (clear_i || enable_i) crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel coordinates from incoming hsync/vsync
// edges, verifies line/frame timing, and emits coordinate-tagged active
// pixels once locked. x/y hold the coordinate of the most recent p_tick
// sample. Optional frame checksum outputs are enabled by VGA_RX_CRC_EN.
module vga_sync_receiver #(
   parameter int   H_DISPLAY = vga_rx_pkg::H_DISPLAY,
   parameter int   H_FRONT   = vga_rx_pkg::H_FRONT,
   parameter int   H_SYNC    = vga_rx_pkg::H_SYNC,
   parameter int   H_BACK    = vga_rx_pkg::H_BACK,
   parameter int   V_DISPLAY = vga_rx_pkg::V_DISPLAY,
   parameter int   V_FRONT   = vga_rx_pkg::V_FRONT,
   parameter int   V_SYNC    = vga_rx_pkg::V_SYNC,
   parameter int   V_BACK    = vga_rx_pkg::V_BACK,
   parameter logic SYNC_POL  = vga_rx_pkg::SYNC_POL
) (
   input  logic        clk_50MHz,
   input  logic        reset_n,
   input  logic        p_tick,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [29:0] rgb_in,
   output logic        locked,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        pix_valid,
   output logic [29:0] pix_rgb,
   output logic        frame_start,
   output logic        sync_err
`ifdef VGA_RX_CRC_EN
   ,
   output logic [15:0] frame_crc,
   output logic        crc_valid
`endif
);
   import vga_rx_pkg::*;

   localparam logic [9:0] XLast  = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] YLast  = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] XSync  = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] YSync  = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] XActive = 10'(H_DISPLAY);
   localparam logic [9:0] YActive = 10'(V_DISPLAY);

   rx_state_e   state_q, state_d;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic        hs_q, vs_q;
   logic [29:0] rgb_q;
   logic        locked_q, pixValid_q, frameStart_q, syncErr_q;

   logic        hsEdge, vsEdge, hsBad, vsBad, violation;
   logic [9:0]  xRun, yRun;
   logic        lockNext, activeNext, originNext;

   // Next coordinate, edge checks and state decision for the current sample
   always_comb begin
      hsEdge = (hsync == SYNC_POL) && (hs_q != SYNC_POL);
      vsEdge = (vsync == SYNC_POL) && (vs_q != SYNC_POL);
      xRun   = (x_q == XLast) ? '0 : x_q + 10'd1;
      if (x_q == XLast) yRun = (y_q == YLast) ? '0 : y_q + 10'd1;
      else              yRun = y_q;
      hsBad  = hsEdge != (xRun == XSync);
      vsBad  = vsEdge != ((xRun == '0) && (yRun == YSync));

      state_d   = state_q;
      x_d       = xRun;
      y_d       = yRun;
      violation = 1'b0;
      case (state_q)
         HUNT: begin
            if (vsEdge) begin
               x_d     = '0;
               y_d     = YSync;
               state_d = CHECK;
            end else if (hsEdge) begin
               x_d = XSync;
            end
         end
         default: begin
            if (hsBad || vsBad) begin
               violation = 1'b1;
               state_d   = HUNT;
               if (hsEdge) x_d = XSync;
               if (vsEdge) begin
                  x_d = '0;
                  y_d = YSync;
               end
            end else if (vsEdge) begin
               state_d = LOCKED;
            end
         end
      endcase

      lockNext   = (state_d == LOCKED);
      activeNext = lockNext && (x_d < XActive) && (y_d < YActive);
      originNext = lockNext && (x_d == '0) && (y_d == '0);
   end

   // Receiver FSM, counters and registered outputs; pulses last one clock
   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= HUNT;
         x_q          <= '0;
         y_q          <= '0;
         hs_q         <= ~SYNC_POL;
         vs_q         <= ~SYNC_POL;
         rgb_q        <= '0;
         locked_q     <= 1'b0;
         pixValid_q   <= 1'b0;
         frameStart_q <= 1'b0;
         syncErr_q    <= 1'b0;
      end else if (p_tick) begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         hs_q         <= hsync;
         vs_q         <= vsync;
         rgb_q        <= rgb_in;
         locked_q     <= lockNext;
         pixValid_q   <= activeNext;
         frameStart_q <= originNext;
         syncErr_q    <= violation;
      end else begin
         pixValid_q   <= 1'b0;
         frameStart_q <= 1'b0;
         syncErr_q    <= 1'b0;
      end
   end

   assign locked      = locked_q;
   assign x           = x_q;
   assign y           = y_q;
   assign pix_valid   = pixValid_q;
   assign pix_rgb     = rgb_q;
   assign frame_start = frameStart_q;
   assign sync_err    = syncErr_q;

`ifdef VGA_RX_CRC_EN
   logic [15:0] crcRun;
   logic        frameOpen_q;
   logic [15:0] frameCrc_q;
   logic        crcValid_q;

   vga_rx_crc16 uCrc (
      .clk_i    (clk_50MHz),
      .rst_ni   (reset_n),
      .clear_i  (p_tick && originNext),
      .enable_i (p_tick && activeNext),
      .data_i   (rgb_in),
      .crc_o    (crcRun)
   );

   // Publish the checksum of a frame that stayed locked from its first pixel
   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         frameOpen_q <= 1'b0;
         frameCrc_q  <= '0;
         crcValid_q  <= 1'b0;
      end else begin
         crcValid_q <= 1'b0;
         if (p_tick) begin
            if (lockNext && (state_q == LOCKED) && vsEdge && frameOpen_q) begin
               frameCrc_q <= crcRun;
               crcValid_q <= 1'b1;
            end
            if (!lockNext)       frameOpen_q <= 1'b0;
            else if (originNext) frameOpen_q <= 1'b1;
         end
      end
   end

   assign frame_crc = frameCrc_q;
   assign crc_valid = crcValid_q;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver using a reduced timing so whole
// frames fit in a short run. A scenario table drives clean and faulted sync
// streams; every tick is compared with a position-based reference model and
// each scenario's totals are compared with hand-derived figures.
module tb_vga_sync_receiver;

   localparam int HD = 16, HF = 2, HS = 3, HB = 3;
   localparam int VD = 8,  VF = 1, VS = 2, VB = 2;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int HSS = HD + HF;
   localparam int VSS = VD + VF;

   logic        clk_50MHz = 1'b0;
   logic        reset_n   = 1'b0;
   logic        p_tick    = 1'b0;
   logic        hsync     = 1'b0;
   logic        vsync     = 1'b0;
   logic [29:0] rgb_in    = '0;
   logic        locked;
   logic [9:0]  x, y;
   logic        pix_valid;
   logic [29:0] pix_rgb;
   logic        frame_start;
   logic        sync_err;
`ifdef VGA_RX_CRC_EN
   logic [15:0] frame_crc;
   logic        crc_valid;
   logic [15:0] crcLog[$];
`endif

   always #5 clk_50MHz = ~clk_50MHz;

   vga_sync_receiver #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_POL(1'b1)
   ) dut (
      .clk_50MHz   (clk_50MHz),
      .reset_n     (reset_n),
      .p_tick      (p_tick),
      .hsync       (hsync),
      .vsync       (vsync),
      .rgb_in      (rgb_in),
      .locked      (locked),
      .x           (x),
      .y           (y),
      .pix_valid   (pix_valid),
      .pix_rgb     (pix_rgb),
      .frame_start (frame_start),
`ifdef VGA_RX_CRC_EN
      .frame_crc   (frame_crc),
      .crc_valid   (crc_valid),
`endif
      .sync_err    (sync_err)
   );

   typedef struct packed {
      logic        locked;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        pv;
      logic [29:0] rgb;
      logic        fs;
      logic        se;
   } obs_t;

   typedef struct {
      string       name;
      int          frames;
      int          fault;
      int          fLine;
      int          fX;
      bit          useConst;
      logic [29:0] rgb;
      int          expErr;
      int          expPix;
      int          expFs;
      int          expLocked;
      int          expRise;
   } scen_t;

   int   checks = 0;
   int   errors = 0;

   // Reference model: mode 0 hunting, 1 checking, 2 locked; mPos is the
   // linear frame position (y*HT+x) of the last sample.
   int   mMode, mPos;
   bit   mPrevHs, mPrevVs;
   obs_t mExp;

   int   gPos = 0;
   int   cntErr, cntPix, cntFs, lastRise, tickIdx;
   bit   prevLocked = 1'b0;

   function automatic obs_t sampleDut();
      obs_t o;
      o.locked = locked; o.x = x; o.y = y; o.pv = pix_valid;
      o.rgb = pix_rgb; o.fs = frame_start; o.se = sync_err;
      return o;
   endfunction

   task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s @%0t: got locked=%0b x=%0d y=%0d pv=%0b rgb=%h fs=%0b err=%0b, expected locked=%0b x=%0d y=%0d pv=%0b rgb=%h fs=%0b err=%0b",
                  name, $time, act.locked, act.x, act.y, act.pv, act.rgb, act.fs, act.se,
                  exp.locked, exp.x, exp.y, exp.pv, exp.rgb, exp.fs, exp.se);
      end
   endtask

   task automatic checkInt(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mMode = 0; mPos = 0; mPrevHs = 1'b0; mPrevVs = 1'b0; mExp = '0;
   endtask

   task automatic modelSample(input bit hs, input bit vs, input logic [29:0] rgb);
      int cur, cx, cy;
      bit he, ve, err, lk;
      cur = (mPos + 1) % FRAME;
      cx  = cur % HT;
      cy  = cur / HT;
      he  = hs && !mPrevHs;
      ve  = vs && !mPrevVs;
      err = 1'b0;
      if (mMode == 0) begin
         if (ve) begin cur = VSS * HT; mMode = 1; end
         else if (he) cur = cy * HT + HSS;
      end else begin
         err = (he != (cx == HSS)) || (ve != (cur == VSS * HT));
         if (err) begin
            mMode = 0;
            if (he) cur = cy * HT + HSS;
            if (ve) cur = VSS * HT;
         end else if (ve) mMode = 2;
      end
      mPos = cur;
      cx = cur % HT;
      cy = cur / HT;
      lk = (mMode == 2);
      mExp.locked = lk;
      mExp.x      = 10'(cx);
      mExp.y      = 10'(cy);
      mExp.pv     = lk && (cx < HD) && (cy < VD);
      mExp.rgb    = rgb;
      mExp.fs     = lk && (cur == 0);
      mExp.se     = err;
      mPrevHs = hs;
      mPrevVs = vs;
   endtask

   // One pixel tick followed by one idle clock carrying junk on the inputs
   task automatic applyStimulus(input bit hs, input bit vs, input logic [29:0] rgb);
      obs_t act, idleExp;
      p_tick = 1'b1; hsync = hs; vsync = vs; rgb_in = rgb;
      @(posedge clk_50MHz); #1;
      if (reset_n) modelSample(hs, vs, rgb);
      else         modelReset();
      act = sampleDut();
      checkOutput("tick", act, mExp);
      cntErr += int'(act.se);
      cntPix += int'(act.pv);
      cntFs  += int'(act.fs);
      if (act.locked && !prevLocked) lastRise = tickIdx;
      prevLocked = act.locked;
      tickIdx++;
`ifdef VGA_RX_CRC_EN
      if (crc_valid) crcLog.push_back(frame_crc);
`endif
      p_tick = 1'b0; hsync = 1'($urandom); vsync = 1'($urandom); rgb_in = 30'($urandom);
      @(posedge clk_50MHz); #1;
      idleExp = mExp; idleExp.pv = 1'b0; idleExp.fs = 1'b0; idleExp.se = 1'b0;
      checkOutput("idle", sampleDut(), idleExp);
   endtask

   // Timing generator with optional faults: 1 early hsync, 2 missing hsync,
   // 3 missing vsync, 4 vsync starting at (fX, fLine)
   task automatic genTick(input int fault, input int fLine, input int fX, input bit faultOn,
                          input bit useConst, input logic [29:0] constRgb);
      int gx, gy;
      bit hs, vs;
      gx = gPos % HT;
      gy = gPos / HT;
      hs = (gx >= HSS) && (gx < HSS + HS);
      vs = (gy >= VSS) && (gy < VSS + VS);
      if (faultOn) begin
         case (fault)
            1: if (gy == fLine && gx >= fX && gx < HSS + HS) hs = 1'b1;
            2: if (gy == fLine) hs = 1'b0;
            3: vs = 1'b0;
            4: if (gPos >= fLine * HT + fX && gy < VSS + VS) vs = 1'b1;
            default: ;
         endcase
      end
      applyStimulus(hs, vs, useConst ? constRgb : 30'($urandom));
      gPos = (gPos + 1) % FRAME;
   endtask

   task automatic clearCounts();
      cntErr = 0; cntPix = 0; cntFs = 0; lastRise = -1; tickIdx = 0;
   endtask

`ifdef VGA_RX_CRC_EN
   function automatic logic [15:0] crcRefConst(input logic [29:0] w, input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int k = 0; k < n; k++) begin
         for (int i = 29; i >= 0; i--) begin
            fb = c[15] ^ w[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction
`endif

   scen_t tbl [6];
   int    p0;

   initial begin
      tbl[0] = '{"acquire",   3, 0, 0,       0,       1'b0, 30'h0,        0, HD*VD,                  1, 1, FRAME + VSS*HT};
      tbl[1] = '{"hsEarly",   3, 1, 4,       HSS - 3, 1'b0, 30'h0,        1, 4*HD + HSS - 3 + HD*VD, 2, 1, FRAME + VSS*HT};
      tbl[2] = '{"hsMissing", 3, 2, 2,       0,       1'b0, 30'h0,        1, 3*HD + HD*VD,           2, 1, FRAME + VSS*HT};
      tbl[3] = '{"vsDrop",    4, 3, 0,       0,       1'b0, 30'h0,        1, 2*HD*VD,                2, 1, 2*FRAME + VSS*HT};
      tbl[4] = '{"vsEarly",   4, 4, VSS - 1, HSS,     1'b0, 30'h0,        1, 2*HD*VD,                2, 1, 2*FRAME + VSS*HT};
      tbl[5] = '{"constRgb",  2, 0, 0,       0,       1'b1, 30'h3FF00000, 0, 2*HD*VD,                2, 1, -1};

      modelReset();
      repeat (3) @(posedge clk_50MHz);
      #1;
      checkOutput("resetState", sampleDut(), '0);
      reset_n = 1'b1;

      for (int s = 0; s < 6; s++) begin
         clearCounts();
`ifdef VGA_RX_CRC_EN
         crcLog.delete();
`endif
         for (int f = 0; f < tbl[s].frames; f++)
            for (int p = 0; p < FRAME; p++)
               genTick(tbl[s].fault, tbl[s].fLine, tbl[s].fX, f == 0, tbl[s].useConst, tbl[s].rgb);
         checkInt({tbl[s].name, " syncErr count"},  cntErr, tbl[s].expErr);
         checkInt({tbl[s].name, " pixValid count"}, cntPix, tbl[s].expPix);
         checkInt({tbl[s].name, " frameStart count"}, cntFs, tbl[s].expFs);
         checkInt({tbl[s].name, " locked at end"}, int'(locked), tbl[s].expLocked);
         checkInt({tbl[s].name, " lock rise tick"}, lastRise, tbl[s].expRise);
`ifdef VGA_RX_CRC_EN
         if (tbl[s].useConst) begin
            checkInt("crcValid count", crcLog.size(), tbl[s].frames);
            foreach (crcLog[i])
               checkInt("frameCrc value", int'(crcLog[i]), int'(crcRefConst(tbl[s].rgb, HD*VD)));
         end
`endif
      end

      // Asynchronous reset in the middle of a locked line, then recovery
      for (int i = 0; i < 4*HT + 5; i++) genTick(0, 0, 0, 1'b0, 1'b0, 30'h0);
      reset_n = 1'b0;
      #2;
      checkOutput("asyncReset", sampleDut(), '0);
      modelReset();
      for (int i = 0; i < 3; i++) genTick(0, 0, 0, 1'b0, 1'b0, 30'h0);
      reset_n = 1'b1;
      clearCounts();
      p0 = gPos;
      for (int i = 0; i < (FRAME - p0) + 2*FRAME; i++) genTick(0, 0, 0, 1'b0, 1'b0, 30'h0);
      checkInt("relock syncErr count", cntErr, 0);
      checkInt("relock frameStart count", cntFs, 1);
      checkInt("relock locked", int'(locked), 1);
      checkInt("relock rise tick", lastRise, (FRAME - p0) + VSS*HT);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
